// File: rtl/esfa_pkg.sv
// Shared types and constants for the ESFA cell-bus controller.
// Configuration macro: ESFA_FREE_COUNT_EN (adds the free_count output to the top).
package esfa_pkg;

    // Host operation codes; value 3 is reserved and answered with a miss.
    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_INSERT = 2'd1,
        OP_RANK   = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    // Cell-bus selector opcodes.
    localparam logic [7:0] SEL_UPDATE       = 8'd0;
    localparam logic [7:0] SEL_LOOKUP       = 8'd1;
    localparam logic [7:0] SEL_ENCODE       = 8'd2;
    localparam logic [7:0] SEL_CONGRUE_UP   = 8'd3;
    localparam logic [7:0] SEL_CONGRUE_DOWN = 8'd4;
    localparam logic [7:0] SEL_MARK_AVAIL   = 8'd5;
    localparam logic [7:0] SEL_ENRANK       = 8'd6;
    localparam logic [7:0] SEL_DEBUG        = 8'd7;

    // Metadata driven on an idle bus; it forces every cell's new_bool low.
    localparam logic [7:0] IDLE_MD = 8'hFF;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

endpackage

// File: rtl/esfa_cell_controller_prio_enc.sv
// Lowest-set-bit priority encoder: picks the lowest cell handle that reported a hit.
module esfa_prio_enc #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) begin
                idx = IW'(k);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/esfa_cell_controller.sv
// ESFA cell-bus initiator: turns one host op into a scan / sample / optional
// write sequence on the broadcast bus and returns one registered response.
// Configuration macro: ESFA_FREE_COUNT_EN (adds free_count output).
module esfa_cell_controller
    import esfa_pkg::*;
#(
    parameter int NUM_CELLS = 8,
    parameter int DW        = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [DW-1:0]           req_handle,
    input  logic [DW-1:0]           req_index,
    input  logic [DW-1:0]           req_value,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_hit,
    output logic [DW-1:0]           rsp_value,
    output logic [DW-1:0]           rsp_context,
    output logic [7:0]              cell_selector,
    output logic [DW-1:0]           cell_metadata,
    output logic                    cell_is_metadata,
    output logic [DW-1:0]           cell_index,
    output logic [DW-1:0]           cell_value,
    input  logic [NUM_CELLS-1:0]    cell_bool,
    input  logic [NUM_CELLS*DW-1:0] cell_result,
    input  logic [NUM_CELLS*DW-1:0] cell_context
`ifdef ESFA_FREE_COUNT_EN
    ,
    output logic [$clog2(NUM_CELLS+1)-1:0] free_count
`endif
);

    localparam int IW = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;

    state_e        state, state_n;
    op_e           op_q;
    logic [DW-1:0] handle_q, index_q, value_q;
    logic          latch_en;

    logic          req_ready_n, rsp_valid_n, rsp_hit_n;
    logic [DW-1:0] rsp_value_n, rsp_context_n;
    logic [7:0]    sel_n;
    logic [DW-1:0] md_n, idx_n, val_n;
    logic          ism_n;

    logic [IW-1:0] hit_idx;
    logic          hit_any;
    logic [DW-1:0] hit_result, hit_context;

    esfa_prio_enc #(.N(NUM_CELLS), .IW(IW)) u_prio_enc (
        .req (cell_bool),
        .idx (hit_idx),
        .any (hit_any)
    );

    assign hit_result  = cell_result[int'(hit_idx)*DW +: DW];
    assign hit_context = cell_context[int'(hit_idx)*DW +: DW];

    // Next state plus the next value of every registered output.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_n       = state;
        latch_en      = 1'b0;
        req_ready_n   = 1'b0;
        rsp_valid_n   = rsp_valid;
        rsp_hit_n     = rsp_hit;
        rsp_value_n   = rsp_value;
        rsp_context_n = rsp_context;
        sel_n         = SEL_DEBUG;
        md_n          = DW'(IDLE_MD);
        ism_n         = 1'b0;
        idx_n         = '0;
        val_n         = '0;
        unique case (state)
            ST_IDLE: begin
                req_ready_n = 1'b1;
                if (req_valid && req_ready) begin
                    latch_en    = 1'b1;
                    req_ready_n = 1'b0;
                    state_n     = ST_SCAN;
                    case (op_e'(req_op))
                        OP_LOOKUP: begin
                            sel_n = SEL_LOOKUP;
                            md_n  = req_handle;
                            ism_n = 1'b1;
                            idx_n = req_index;
                        end
                        OP_INSERT: begin
                            // Any metadata other than the idle value lets free cells answer.
                            sel_n = SEL_MARK_AVAIL;
                            md_n  = '0;
                        end
                        OP_RANK: begin
                            sel_n = SEL_ENRANK;
                            md_n  = req_handle;
                            ism_n = 1'b1;
                        end
                        default: begin
                            state_n       = ST_RESP;
                            rsp_valid_n   = 1'b1;
                            rsp_hit_n     = 1'b0;
                            rsp_value_n   = '0;
                            rsp_context_n = '0;
                        end
                    endcase
                end
            end
            ST_SCAN: state_n = ST_SAMPLE;
            ST_SAMPLE: begin
                rsp_hit_n     = hit_any;
                rsp_context_n = hit_any ? hit_context : '0;
                if (op_q == OP_INSERT) rsp_value_n = hit_any ? DW'(hit_idx) : '0;
                else                   rsp_value_n = hit_any ? hit_result : '0;
                if (op_q == OP_INSERT && hit_any) begin
                    // Cells write on every cycle sel=0 is held, so WRITE lasts one cycle only.
                    state_n = ST_WRITE;
                    sel_n   = SEL_UPDATE;
                    md_n    = DW'(hit_idx);
                    ism_n   = 1'b1;
                    idx_n   = index_q;
                    val_n   = value_q;
                end else begin
                    state_n     = ST_RESP;
                    rsp_valid_n = 1'b1;
                end
            end
            ST_WRITE: begin
                state_n     = ST_RESP;
                rsp_valid_n = 1'b1;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_n     = ST_IDLE;
                    rsp_valid_n = 1'b0;
                    req_ready_n = 1'b1;
                end
            end
            default: begin
                state_n     = ST_IDLE;
                req_ready_n = 1'b1;
            end
        endcase
    end

    // State register and registered host/bus outputs; reset parks the bus idle.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state            <= ST_IDLE;
            req_ready        <= 1'b1;
            rsp_valid        <= 1'b0;
            rsp_hit          <= 1'b0;
            rsp_value        <= '0;
            rsp_context      <= '0;
            cell_selector    <= SEL_DEBUG;
            cell_metadata    <= DW'(IDLE_MD);
            cell_is_metadata <= 1'b0;
            cell_index       <= '0;
            cell_value       <= '0;
        end else begin
            state            <= state_n;
            req_ready        <= req_ready_n;
            rsp_valid        <= rsp_valid_n;
            rsp_hit          <= rsp_hit_n;
            rsp_value        <= rsp_value_n;
            rsp_context      <= rsp_context_n;
            cell_selector    <= sel_n;
            cell_metadata    <= md_n;
            cell_is_metadata <= ism_n;
            cell_index       <= idx_n;
            cell_value       <= val_n;
        end
    end

    // Capture the accepted request fields for use in later phases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= OP_LOOKUP;
            handle_q <= '0;
            index_q  <= '0;
            value_q  <= '0;
        end else if (latch_en) begin
            op_q     <= op_e'(req_op);
            handle_q <= req_handle;
            index_q  <= req_index;
            value_q  <= req_value;
        end
    end

`ifdef ESFA_FREE_COUNT_EN
    localparam int FCW = $clog2(NUM_CELLS + 1);
    logic [FCW-1:0] free_pop;

    // Number of cells that reported free during an INSERT scan.
    always_comb begin
        free_pop = '0;
        for (int k = 0; k < NUM_CELLS; k++) free_pop = free_pop + FCW'(cell_bool[k]);
    end

    // Reload the free count on each INSERT sample, then account for the write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                       free_count <= FCW'(NUM_CELLS);
        else if (state == ST_SAMPLE && op_q == OP_INSERT) free_count <= free_pop;
        else if (state == ST_WRITE)                      free_count <= free_count - 1'b1;
    end
`endif

endmodule

// File: tb/tb_esfa_cell_controller.sv
// Directed bench for esfa_cell_controller with a small behavioural cell array.
// Cells: one array (code 0); LOOKUP returns value with context = handle+1,
// RANK returns handle+1, MARK_AVAIL flags unused cells, UPDATE writes cell md.
module tb_esfa_cell_controller;
    import esfa_pkg::*;

    localparam int NC = 8;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid, req_ready;
    logic [1:0]      req_op;
    logic [DW-1:0]   req_handle, req_index, req_value;
    logic            rsp_valid, rsp_ready, rsp_hit;
    logic [DW-1:0]   rsp_value, rsp_context;
    logic [7:0]      cell_selector;
    logic [DW-1:0]   cell_metadata, cell_index, cell_value;
    logic            cell_is_metadata;
    logic [NC-1:0]   cell_bool;
    logic [NC*DW-1:0] cell_result, cell_context;
`ifdef ESFA_FREE_COUNT_EN
    logic [3:0]      free_count;
`endif

    always #5 clk = ~clk;

    esfa_cell_controller #(.NUM_CELLS(NC), .DW(DW)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_handle       (req_handle),
        .req_index        (req_index),
        .req_value        (req_value),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_hit          (rsp_hit),
        .rsp_value        (rsp_value),
        .rsp_context      (rsp_context),
        .cell_selector    (cell_selector),
        .cell_metadata    (cell_metadata),
        .cell_is_metadata (cell_is_metadata),
        .cell_index       (cell_index),
        .cell_value       (cell_value),
        .cell_bool        (cell_bool),
        .cell_result      (cell_result),
        .cell_context     (cell_context)
`ifdef ESFA_FREE_COUNT_EN
        ,
        .free_count       (free_count)
`endif
    );

    // Behavioural cell array: registered outputs, one cycle after the broadcast.
    logic [NC-1:0] used;
    logic [DW-1:0] c_idx [NC];
    logic [DW-1:0] c_val [NC];
    logic          model_clear;

    always @(posedge clk) begin
        logic [NC-1:0]    b;
        logic [NC*DW-1:0] r, c;
        b = '0;
        r = '0;
        c = '0;
        if (model_clear) used <= '0;
        if (cell_metadata != 8'hFF) begin
            for (int k = 0; k < NC; k++) begin
                case (cell_selector)
                    SEL_UPDATE: if (cell_is_metadata && cell_metadata == DW'(k)) begin
                        used[k]  <= 1'b1;
                        c_idx[k] <= cell_index;
                        c_val[k] <= cell_value;
                    end
                    SEL_LOOKUP: if (cell_is_metadata && used[k] === 1'b1 && cell_metadata == 8'h00
                                    && c_idx[k] == cell_index) begin
                        b[k]         = 1'b1;
                        r[k*DW +: DW] = c_val[k];
                        c[k*DW +: DW] = DW'(k + 1);
                    end
                    SEL_ENRANK: if (cell_is_metadata && used[k] === 1'b1 && cell_metadata == 8'h00) begin
                        b[k]         = 1'b1;
                        r[k*DW +: DW] = DW'(k + 1);
                        c[k*DW +: DW] = DW'(k + 1);
                    end
                    SEL_MARK_AVAIL: if (used[k] !== 1'b1) b[k] = 1'b1;
                    default: ;
                endcase
            end
        end
        cell_bool    <= b;
        cell_result  <= r;
        cell_context <= c;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request (starting just after a negedge) and wait for rsp_valid.
    task automatic run_op(input logic [1:0] op, input logic [7:0] h, input logic [7:0] i,
                          input logic [7:0] v, output int lat, output int n_wr, output logic [7:0] wr_md);
        req_op = op; req_handle = h; req_index = i; req_value = v; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; n_wr = 0; wr_md = 8'hFF;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (cell_selector == SEL_UPDATE) begin
                n_wr++;
                wr_md = cell_metadata;
            end
            if (rsp_valid) break;
        end
    endtask

    // Full transaction with response checks and the return to IDLE.
    task automatic txn(input string tag, input logic [1:0] op, input logic [7:0] h, input logic [7:0] i,
                       input logic [7:0] v, input logic e_hit, input logic [7:0] e_val,
                       input logic [7:0] e_ctx, input int e_lat, input int e_wr, input logic [7:0] e_md);
        int lat, n_wr;
        logic [7:0] wr_md;
        run_op(op, h, i, v, lat, n_wr, wr_md);
        check({tag, ".latency"}, 32'(lat), 32'(e_lat));
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".rsp_hit"}, 32'(rsp_hit), 32'(e_hit));
        check({tag, ".rsp_value"}, 32'(rsp_value), 32'(e_val));
        check({tag, ".rsp_context"}, 32'(rsp_context), 32'(e_ctx));
        check({tag, ".write_cycles"}, 32'(n_wr), 32'(e_wr));
        if (e_wr > 0) check({tag, ".write_md"}, 32'(wr_md), 32'(e_md));
        @(negedge clk);
        check({tag, ".done_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, ".done_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic check_bus_idle(input string tag);
        check({tag, ".sel"}, 32'(cell_selector), 32'(SEL_DEBUG));
        check({tag, ".md"}, 32'(cell_metadata), 32'hFF);
        check({tag, ".ism"}, 32'(cell_is_metadata), 32'd0);
        check({tag, ".idx"}, 32'(cell_index), 32'd0);
        check({tag, ".val"}, 32'(cell_value), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, n_wr;
        logic [7:0] wr_md;

        reset = 1'b1; model_clear = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        req_op = 2'd0; req_handle = '0; req_index = '0; req_value = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0; model_clear = 1'b0;

        // Reset state.
        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_hit", 32'(rsp_hit), 32'd0);
        check("rst.rsp_value", 32'(rsp_value), 32'd0);
        check("rst.rsp_context", 32'(rsp_context), 32'd0);
        check_bus_idle("rst.bus");
`ifdef ESFA_FREE_COUNT_EN
        check("rst.free_count", 32'(free_count), 32'd8);
`endif

        // Empty array: lookup misses.
        txn("lookup_empty", OP_LOOKUP, 8'd0, 8'd3, 8'd0, 1'b0, 8'd0, 8'd0, 3, 0, 8'd0);
        check_bus_idle("after_lookup_empty");

        // Two inserts allocate handles 0 and 1.
        txn("insert0", OP_INSERT, 8'd0, 8'd3, 8'h5A, 1'b1, 8'd0, 8'd0, 4, 1, 8'd0);
`ifdef ESFA_FREE_COUNT_EN
        check("insert0.free_count", 32'(free_count), 32'd7);
`endif
        txn("insert1", OP_INSERT, 8'd0, 8'd5, 8'hA5, 1'b1, 8'd1, 8'd0, 4, 1, 8'd1);
`ifdef ESFA_FREE_COUNT_EN
        check("insert1.free_count", 32'(free_count), 32'd6);
`endif

        txn("lookup_hit", OP_LOOKUP, 8'd0, 8'd3, 8'd0, 1'b1, 8'h5A, 8'd1, 3, 0, 8'd0);
        txn("rank", OP_RANK, 8'd0, 8'd0, 8'd0, 1'b1, 8'd1, 8'd1, 3, 0, 8'd0);
        txn("lookup_miss", OP_LOOKUP, 8'd0, 8'd4, 8'd0, 1'b0, 8'd0, 8'd0, 3, 0, 8'd0);
        txn("rank_other_array", OP_RANK, 8'd2, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 3, 0, 8'd0);
        txn("reserved", OP_RSVD, 8'd0, 8'd3, 8'd0, 1'b0, 8'd0, 8'd0, 1, 0, 8'd0);

        // Back-pressure: response held for 5 cycles, new request ignored.
        rsp_ready = 1'b0;
        run_op(OP_LOOKUP, 8'd0, 8'd5, 8'd0, lat, n_wr, wr_md);
        check("hold.latency", 32'(lat), 32'd3);
        check("hold.rsp_hit", 32'(rsp_hit), 32'd1);
        check("hold.rsp_value", 32'(rsp_value), 32'hA5);
        check("hold.rsp_context", 32'(rsp_context), 32'd2);
        req_op = OP_LOOKUP; req_handle = 8'd0; req_index = 8'd3; req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold.rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold.rsp_value_stable", 32'(rsp_value), 32'hA5);
            check("hold.rsp_context_stable", 32'(rsp_context), 32'd2);
            check("hold.req_ready", 32'(req_ready), 32'd0);
            check("hold.bus_sel", 32'(cell_selector), 32'(SEL_DEBUG));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("hold.released_rsp_valid", 32'(rsp_valid), 32'd0);
        check("hold.released_req_ready", 32'(req_ready), 32'd1);
        check("hold.released_sel", 32'(cell_selector), 32'(SEL_DEBUG));

        // Fill the remaining six cells.
        for (int n = 2; n < 8; n++) begin
            txn("fill", OP_INSERT, 8'd0, 8'(8 + n), 8'(n), 1'b1, 8'(n), 8'd0, 4, 1, 8'(n));
`ifdef ESFA_FREE_COUNT_EN
            check("fill.free_count", 32'(free_count), 32'(7 - n));
`endif
        end

        // Full array: insert misses and issues no write.
        txn("insert_full", OP_INSERT, 8'd0, 8'd20, 8'h33, 1'b0, 8'd0, 8'd0, 3, 0, 8'd0);
`ifdef ESFA_FREE_COUNT_EN
        check("insert_full.free_count", 32'(free_count), 32'd0);
`endif
        txn("lookup_last", OP_LOOKUP, 8'd0, 8'd15, 8'd0, 1'b1, 8'd7, 8'd8, 3, 0, 8'd0);

        // Reset during WRITE on a freshly cleared array.
        model_clear = 1'b1;
        @(negedge clk);
        model_clear = 1'b0;
        req_op = OP_INSERT; req_handle = 8'd0; req_index = 8'd3; req_value = 8'h77; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (cell_selector == SEL_UPDATE) break;
        end
        check("rst_write.reached_write", 32'(lat), 32'd3);
        reset = 1'b1;
        #1;
        check("rst_write.req_ready", 32'(req_ready), 32'd1);
        check("rst_write.rsp_valid", 32'(rsp_valid), 32'd0);
        check_bus_idle("rst_write.bus");
        @(negedge clk);
        reset = 1'b0;
        check("rst_write.idle_req_ready", 32'(req_ready), 32'd1);
        check("rst_write.idle_sel", 32'(cell_selector), 32'(SEL_DEBUG));
`ifdef ESFA_FREE_COUNT_EN
        check("rst_write.free_count", 32'(free_count), 32'd8);
`endif
        txn("post_rst_lookup", OP_LOOKUP, 8'd0, 8'd3, 8'd0, 1'b0, 8'd0, 8'd0, 3, 0, 8'd0);
        txn("post_rst_insert", OP_INSERT, 8'd0, 8'd3, 8'h77, 1'b1, 8'd0, 8'd0, 4, 1, 8'd0);
        txn("post_rst_lookup_hit", OP_LOOKUP, 8'd0, 8'd3, 8'd0, 1'b1, 8'h77, 8'd1, 3, 0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
